// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display with frame-synchronous loading.
// Optional build macro SEG_LZB_EN enables leading-zero blanking of digits 3..1.
module seg_scan_ctrl #(
  parameter int DIGIT_TICKS = 3000,
  parameter int BLANK_TICKS = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  output logic [6:0]  seg,
  output logic [3:0]  comm,
  output logic        frame_done
);

  localparam int TW = $clog2(DIGIT_TICKS);
  localparam logic [TW-1:0] TICK_LAST  = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] TICK_BLANK = TW'(BLANK_TICKS);

  typedef enum logic {PH_BLANK, PH_DRIVE} phase_t;

  logic [15:0]   act;
  logic [15:0]   pend;
  logic          pv;
  logic [1:0]    dig;
  logic [TW-1:0] tick;

  phase_t        phase;
  logic          boundary;
  logic [3:0]    nib;
  logic          lit;
  logic [6:0]    seg_nxt;
  logic [3:0]    comm_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign load_ready = ~pv;

  // Display for the current (dig, tick); registered below so outputs lag one cycle.
  always_comb begin
    boundary = (dig == 2'd3) && (tick == TICK_LAST);
    phase    = (tick < TICK_BLANK) ? PH_BLANK : PH_DRIVE;
    nib      = act[{dig, 2'b00} +: 4];
`ifdef SEG_LZB_EN
    case (dig)
      2'd3:    lit = |act[15:12];
      2'd2:    lit = |act[15:8];
      2'd1:    lit = |act[15:4];
      default: lit = 1'b1;
    endcase
`else
    lit = 1'b1;
`endif
    seg_nxt  = 7'b1111111;
    comm_nxt = 4'b0000;
    if (phase == PH_DRIVE && lit) begin
      seg_nxt  = hex7(nib);
      comm_nxt = 4'b0001 << dig;
    end
  end

  // A transfer needs pv=0 and the boundary swap needs pv=1, so they never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act        <= '0;
      pend       <= '0;
      pv         <= 1'b0;
      dig        <= 2'd0;
      tick       <= '0;
      seg        <= 7'b1111111;
      comm       <= 4'b0000;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_nxt;
      comm       <= comm_nxt;
      frame_done <= boundary;
      if (tick == TICK_LAST) begin
        tick <= '0;
        dig  <= dig + 2'd1;
      end else begin
        tick <= tick + 1'b1;
      end
      if (boundary && pv) begin
        act <= pend;
        pv  <= 1'b0;
      end else if (load_valid && !pv) begin
        pend <= load_data;
        pv   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomised self-checking bench for seg_scan_ctrl, compared against a frame-position reference model.
// Honours SEG_LZB_EN in the model when the macro is defined for the build.
module tb_seg_scan_ctrl;

  localparam int DT    = 8;
  localparam int BT    = 2;
  localparam int FRAME = 4 * DT;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [6:0]  seg;
  logic [3:0]  comm;
  logic        frame_done;

  int checks = 0;
  int fails  = 0;

  // Reference model: position within the 32-cycle frame plus shown/pending values.
  int          m_pos;
  logic [15:0] m_act;
  logic [15:0] m_pend;
  bit          m_pv;
  bit          accepted;
  logic [12:0] exp_vec;
  logic [12:0] got_vec;

  assign got_vec = {seg, comm, frame_done, load_ready};

  seg_scan_ctrl #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .seg(seg), .comm(comm), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] display_at(input int pos, input logic [15:0] a);
    int          slot;
    logic [3:0]  n;
    logic [15:0] upper;
    bit          shown;
    display_at = {7'h7F, 4'h0};
    slot  = pos / DT;
    upper = a >> (4 * slot);
    n     = upper[3:0];
    shown = 1'b1;
`ifdef SEG_LZB_EN
    if (slot > 0 && upper == 16'h0) shown = 1'b0;
`endif
    if ((pos % DT) >= BT && shown) display_at = {HEX[n], 4'(1 << slot)};
  endfunction

  task automatic model_reset();
    m_pos = 0; m_act = '0; m_pend = '0; m_pv = 1'b0;
  endtask

  // One clock edge: predicts outputs from the pre-edge model state, then advances the model.
  task automatic step();
    logic [10:0] d;
    bit          fd;
    d  = display_at(m_pos, m_act);
    fd = (m_pos == FRAME - 1);
    @(posedge clk);
    accepted = 1'b0;
    if (m_pos == FRAME - 1 && m_pv) begin
      m_act = m_pend;
      m_pv  = 1'b0;
    end else if (load_valid && !m_pv) begin
      m_pend   = load_data;
      m_pv     = 1'b1;
      accepted = 1'b1;
    end
    m_pos   = (m_pos + 1) % FRAME;
    exp_vec = {d, fd, !m_pv};
    #1;
    if (accepted) load_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] v);
    load_data  = v;
    load_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_valid = 1'b0; load_data = '0;
    #3;
    checks++;
    if (got_vec !== {7'h7F, 4'h0, 1'b0, 1'b1}) begin
      fails++; $display("[TB] FAIL reset_initial: got %h expected %h", got_vec, {7'h7F, 4'h0, 1'b0, 1'b1});
    end
    @(negedge clk); rst = 1'b0; model_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) applyStimulus(16'h9999);
      step(); checks++;
      if (got_vec !== exp_vec) begin fails++; $display("[TB] FAIL reset_pre: got %h expected %h", got_vec, exp_vec); end
    end
    #2; rst = 1'b1; #1;
    checks++;
    if (got_vec !== {7'h7F, 4'h0, 1'b0, 1'b1}) begin
      fails++; $display("[TB] FAIL reset_async: got %h expected %h", got_vec, {7'h7F, 4'h0, 1'b0, 1'b1});
    end
    load_valid = 1'b0;
    @(negedge clk); rst = 1'b0; model_reset();
    for (int i = 0; i < 12; i++) begin
      step(); checks++;
      if (got_vec !== exp_vec) begin fails++; $display("[TB] FAIL reset_restart: got %h expected %h", got_vec, exp_vec); end
    end
  endtask

  task automatic test_scan_order();
    applyStimulus(16'h1234);
    for (int i = 0; i < 3 * FRAME; i++) begin
      step(); checks++;
      if (got_vec !== exp_vec) begin fails++; $display("[TB] FAIL scan_order: got %h expected %h", got_vec, exp_vec); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    applyStimulus(16'hAAAA);
    for (n = 0; n < 2 * FRAME && load_valid; n++) begin
      step(); checks++;
      if (got_vec !== exp_vec) begin fails++; $display("[TB] FAIL backpressure_first: got %h expected %h", got_vec, exp_vec); end
    end
    if (load_valid) begin checks++; fails++; $display("[TB] FAIL backpressure_timeout: got busy expected accept"); end
    applyStimulus(16'hBBBB);
    for (int i = 0; i < 3 * FRAME; i++) begin
      step(); checks++;
      if (got_vec !== exp_vec) begin fails++; $display("[TB] FAIL backpressure_hold: got %h expected %h", got_vec, exp_vec); end
    end
  endtask

  task automatic test_boundary();
    int n;
    load_valid = 1'b0;
    for (n = 0; n < 3 * FRAME && !(m_pos == FRAME - 1 && !m_pv); n++) begin
      step(); checks++;
      if (got_vec !== exp_vec) begin fails++; $display("[TB] FAIL boundary_wait: got %h expected %h", got_vec, exp_vec); end
    end
    if (!(m_pos == FRAME - 1 && !m_pv)) begin checks++; fails++; $display("[TB] FAIL boundary_timeout: got pos %0d expected %0d", m_pos, FRAME - 1); end
    applyStimulus(16'hC0DE);
    for (int i = 0; i < 3 * FRAME; i++) begin
      step(); checks++;
      if (got_vec !== exp_vec) begin fails++; $display("[TB] FAIL boundary_coincide: got %h expected %h", got_vec, exp_vec); end
    end
  endtask

  task automatic test_no_tearing();
    int n;
    int target;
    target = 2 * DT + BT + 1;
    for (n = 0; n < 3 * FRAME && !(m_pos == target && !m_pv); n++) begin
      step(); checks++;
      if (got_vec !== exp_vec) begin fails++; $display("[TB] FAIL tearing_wait: got %h expected %h", got_vec, exp_vec); end
    end
    if (!(m_pos == target && !m_pv)) begin checks++; fails++; $display("[TB] FAIL tearing_timeout: got pos %0d expected %0d", m_pos, target); end
    applyStimulus(16'h5A3F);
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(); checks++;
      if (got_vec !== exp_vec) begin fails++; $display("[TB] FAIL no_tearing: got %h expected %h", got_vec, exp_vec); end
    end
  endtask

  task automatic test_lzb();
    applyStimulus(16'h0070);
    for (int i = 0; i < 3 * FRAME; i++) begin
      step(); checks++;
      if (got_vec !== exp_vec) begin fails++; $display("[TB] FAIL lzb_0070: got %h expected %h", got_vec, exp_vec); end
    end
    applyStimulus(16'h0000);
    for (int i = 0; i < 3 * FRAME; i++) begin
      step(); checks++;
      if (got_vec !== exp_vec) begin fails++; $display("[TB] FAIL lzb_0000: got %h expected %h", got_vec, exp_vec); end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 12 * FRAME; i++) begin
      if (!load_valid && $urandom_range(0, 7) == 0) begin
        v = 16'($urandom);
        if ($urandom_range(0, 2) == 0) v = v >> (4 * $urandom_range(1, 3));
        applyStimulus(v);
      end
      step(); checks++;
      if (got_vec !== exp_vec) begin fails++; $display("[TB] FAIL random: got %h expected %h", got_vec, exp_vec); end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_backpressure();
    test_boundary();
    test_no_tearing();
    test_lzb();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
